// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types and constants for the host-side program loader.
//               Holds the loader FSM state encoding and the byte/header
//               geometry used by prog_loader and inst_packer.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

  localparam int HDR_BYTES  = 2;  // instruction-count header length in bytes
  localparam int BYTE_WIDTH = 8;  // host stream byte width

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_HDR_LO  = 3'd2,
    ST_HDR_HI  = 3'd3,
    ST_COLLECT = 3'd4,
    ST_EMIT    = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/prog_loader_inst_packer.sv
`default_nettype none
// ============================================================================
// Module      : inst_packer
// Description : Little-endian instruction assembler. Byte k of an
//               instruction lands in bits [8k+7:8k]; the byte index wraps
//               to 0 after the last byte of the word.
// Revision    : 1.0 - initial release
// Ports       :
//   clk_i        in   clock
//   reset_ni     in   asynchronous active-low reset
//   clear_i      in   synchronous clear of index and assembly register
//   byte_valid_i in   accept byte_i into the current lane
//   byte_i       in   host byte
//   word_o       out  assembled instruction (registered)
//   word_done_o  out  current accept completes the instruction
// ============================================================================
module inst_packer
  import prog_loader_pkg::*;
#(
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [BYTE_WIDTH-1:0] byte_i,
  output logic [INST_WIDTH-1:0] word_o,
  output logic                  word_done_o
);

  localparam int BPI   = INST_WIDTH / BYTE_WIDTH;
  localparam int IDX_W = (BPI > 1) ? $clog2(BPI) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPI - 1);

  logic [IDX_W-1:0]      idx_q;
  logic [INST_WIDTH-1:0] word_q;

  assign word_done_o = byte_valid_i && (idx_q == LAST_IDX);
  assign word_o      = word_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      idx_q <= '0;
    end else if (clear_i) begin
      idx_q <= '0;
    end else if (byte_valid_i) begin
      idx_q <= word_done_o ? '0 : idx_q + 1'b1;
    end
  end

  // Lanes are written in place, so the word stays stable while it is emitted.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      word_q <= '0;
    end else if (clear_i) begin
      word_q <= '0;
    end else if (byte_valid_i) begin
      for (int k = 0; k < BPI; k++) begin
        if (idx_q == IDX_W'(k)) begin
          word_q[k*BYTE_WIDTH +: BYTE_WIDTH] <= byte_i;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Host-side program loader. Takes a byte stream over
//               valid/ready, reads a 16-bit little-endian instruction count,
//               rejects counts above inst_limit, then assembles and strobes
//               INST_WIDTH instructions into the control unit after a
//               one-cycle clear pulse.
// Revision    : 1.0 - initial release
// Ports       :
//   clk_i          in   clock
//   reset_ni       in   asynchronous active-low reset
//   start_i        in   begin a session (IDLE/DONE/ERROR only)
//   in_valid_i     in   host byte valid
//   in_data_i      in   host byte
//   in_ready_o     out  loader accepts a byte this cycle
//   ctrl_reset_o   out  one-cycle clear pulse to the control unit
//   load_o         out  instruction strobe
//   load_inst_o    out  instruction qualified by load_o
//   busy_o         out  session active
//   done_o         out  session completed
//   err_o          out  header count exceeded inst_limit
//   loaded_count_o out  instructions emitted this session
// ============================================================================
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int INST_WIDTH = 32,
  parameter int inst_limit = 1024
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic                               start_i,
  input  logic                               in_valid_i,
  input  logic [BYTE_WIDTH-1:0]              in_data_i,
  output logic                               in_ready_o,
  output logic                               ctrl_reset_o,
  output logic                               load_o,
  output logic [INST_WIDTH-1:0]              load_inst_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o,
  output logic [$clog2(inst_limit+1)-1:0]    loaded_count_o
);

  localparam int BPI       = INST_WIDTH / BYTE_WIDTH;
  localparam int cnt_width = $clog2(inst_limit + 1);
  localparam int HDR_W     = BYTE_WIDTH * HDR_BYTES;
  localparam logic [HDR_W:0] LIMIT_EXT = (HDR_W + 1)'(inst_limit);

  loader_state_e state_q, state_d;

  logic [BYTE_WIDTH*(HDR_BYTES-1)-1:0] hdr_lo_q;
  logic [cnt_width-1:0]                remaining_q;
  logic [cnt_width-1:0]                count_q;

  logic ready_q, ready_d;
  logic ctrl_reset_q, ctrl_reset_d;
  logic load_q, load_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic             accept;
  logic [HDR_W-1:0] hdr_count;
  logic             hdr_zero;
  logic             hdr_over;
  logic             pk_clear;
  logic             pk_valid;
  logic             pk_word_done;

  // ready_q mirrors the state decode, so it is the live handshake qualifier.
  assign accept    = in_valid_i && ready_q;
  assign hdr_count = {in_data_i, hdr_lo_q};
  assign hdr_zero  = (hdr_count == '0);
  assign hdr_over  = ({1'b0, hdr_count} > LIMIT_EXT);
  assign pk_clear  = (state_q == ST_CLEAR);
  assign pk_valid  = accept && (state_q == ST_COLLECT);

  inst_packer #(
    .INST_WIDTH (INST_WIDTH)
  ) u_packer (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .clear_i      (pk_clear),
    .byte_valid_i (pk_valid),
    .byte_i       (in_data_i),
    .word_o       (load_inst_o),
    .word_done_o  (pk_word_done)
  );

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start_i) state_d = ST_CLEAR;
      ST_CLEAR:   state_d = ST_HDR_LO;
      ST_HDR_LO:  if (accept) state_d = ST_HDR_HI;
      ST_HDR_HI: begin
        if (accept) begin
          if (hdr_zero)      state_d = ST_DONE;
          else if (hdr_over) state_d = ST_ERROR;
          else               state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: if (pk_word_done) state_d = ST_EMIT;
      // remaining_q is at least 1 here; the <= guards against ever wrapping.
      ST_EMIT:    state_d = (remaining_q <= cnt_width'(1)) ? ST_DONE : ST_COLLECT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    ready_d      = (state_d == ST_HDR_LO) || (state_d == ST_HDR_HI) ||
                   (state_d == ST_COLLECT);
    ctrl_reset_d = (state_d == ST_CLEAR);
    load_d       = (state_d == ST_EMIT);
    busy_d       = (state_d == ST_CLEAR) || ready_d || (state_d == ST_EMIT);
    done_d       = (state_d == ST_DONE);
    err_d        = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ready_q      <= 1'b0;
      ctrl_reset_q <= 1'b0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ready_q      <= ready_d;
      ctrl_reset_q <= ctrl_reset_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Header and instruction counters
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hdr_lo_q    <= '0;
      remaining_q <= '0;
      count_q     <= '0;
    end else begin
      if (state_q == ST_HDR_LO && accept) hdr_lo_q <= in_data_i;
      // Count is cleared on entry to CLEAR so it already reads 0 there.
      if (state_d == ST_CLEAR) begin
        count_q     <= '0;
        remaining_q <= '0;
      end else if (state_q == ST_HDR_HI && accept) begin
        remaining_q <= hdr_count[cnt_width-1:0];
      end else if (state_q == ST_EMIT) begin
        count_q     <= count_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
    end
  end

  assign in_ready_o     = ready_q;
  assign ctrl_reset_o   = ctrl_reset_q;
  assign load_o         = load_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign loaded_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader (INST_WIDTH=32,
//               inst_limit=4). Cycle-accurate vector table plus directed
//               sequences for backpressure, count==limit and reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  localparam int IW    = 32;
  localparam int LIMIT = 4;
  localparam int CW    = $clog2(LIMIT + 1);

  logic          clk_i;
  logic          reset_ni;
  logic          start_i;
  logic          in_valid_i;
  logic [7:0]    in_data_i;
  logic          in_ready_o;
  logic          ctrl_reset_o;
  logic          load_o;
  logic [IW-1:0] load_inst_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [CW-1:0] loaded_count_o;

  prog_loader #(
    .INST_WIDTH (IW),
    .inst_limit (LIMIT)
  ) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .start_i        (start_i),
    .in_valid_i     (in_valid_i),
    .in_data_i      (in_data_i),
    .in_ready_o     (in_ready_o),
    .ctrl_reset_o   (ctrl_reset_o),
    .load_o         (load_o),
    .load_inst_o    (load_inst_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .loaded_count_o (loaded_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          start;
    logic          valid;
    logic [7:0]    data;
    logic          rdy;
    logic          clr;
    logic          ld;
    logic [IW-1:0] inst;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t          vq[$];
  logic [7:0]    tx_q[$];
  logic [IW-1:0] exp_w[$];

  function automatic vec_t mk(logic st, logic v, logic [7:0] d, logic rdy,
                              logic clr, logic ld, logic [IW-1:0] inst,
                              logic busy, logic done, logic err, logic [CW-1:0] cnt);
    vec_t r;
    r.start = st; r.valid = v; r.data = d; r.rdy = rdy; r.clr = clr;
    r.ld = ld; r.inst = inst; r.busy = busy; r.done = done; r.err = err;
    r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packed snapshot of all outputs; load_inst only matters under load_o.
  function automatic logic [63:0] obs();
    return {23'd0, in_ready_o, ctrl_reset_o, load_o,
            (load_o ? load_inst_o : {IW{1'b0}}), busy_o, done_o, err_o,
            loaded_count_o};
  endfunction

  function automatic logic [63:0] expv(vec_t v);
    return {23'd0, v.rdy, v.clr, v.ld, (v.ld ? v.inst : {IW{1'b0}}),
            v.busy, v.done, v.err, v.cnt};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Push tx_q through the handshake (optionally with random valid gaps)
  // and check every load strobe against exp_w.
  task automatic send(input bit gaps, input int budget);
    int nload  = 0;
    int inword = 0;
    int cyc    = 0;
    bit acc;
    while ((tx_q.size() > 0 || nload < exp_w.size()) && cyc < budget) begin
      if (load_o) begin
        if (nload < exp_w.size()) chk("load_inst", 64'(load_inst_o), 64'(exp_w[nload]));
        else chk("extra_load", 64'(load_o), 64'd0);
        chk("load_after_4_bytes", 64'(inword), 64'd4);
        nload++;
        inword = 0;
      end
      if (tx_q.size() > 0) begin
        in_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_data_i  = tx_q[0];
      end else begin
        in_valid_i = 1'b0;
      end
      acc = in_valid_i && in_ready_o;
      tick();
      cyc++;
      if (acc) begin
        void'(tx_q.pop_front());
        inword++;
      end
    end
    in_valid_i = 1'b0;
    if (cyc >= budget) chk("send_timeout", 64'(cyc), 64'(budget - 1));
    exp_w.delete();
    tx_q.delete();
  endtask

  task automatic push(input logic [7:0] b);
    bit acc = 0;
    in_valid_i = 1'b1;
    in_data_i  = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready_o;
      tick();
    end
    in_valid_i = 1'b0;
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    reset_ni   = 1'b0;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = 8'h00;

    // Idle after reset, host byte offered without start
    vq.push_back(mk(0,1,8'h55, 0,0,0,0,0,0,0,0));
    vq.push_back(mk(0,1,8'h55, 0,0,0,0,0,0,0,0));
    // Two-instruction load: 02 00 | 78 56 34 12 | EF BE AD DE
    vq.push_back(mk(1,0,8'h00, 0,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,8'h00, 0,1,0,0,1,0,0,0));
    vq.push_back(mk(0,1,8'h02, 1,0,0,0,1,0,0,0));
    vq.push_back(mk(0,1,8'h00, 1,0,0,0,1,0,0,0));
    vq.push_back(mk(0,1,8'h78, 1,0,0,0,1,0,0,0));
    vq.push_back(mk(1,1,8'h56, 1,0,0,0,1,0,0,0));  // start while busy: ignored
    vq.push_back(mk(0,1,8'h34, 1,0,0,0,1,0,0,0));
    vq.push_back(mk(0,1,8'h12, 1,0,0,0,1,0,0,0));
    vq.push_back(mk(0,1,8'hEF, 0,0,1,32'h12345678,1,0,0,0));  // held, not taken
    vq.push_back(mk(0,1,8'hEF, 1,0,0,0,1,0,0,1));
    vq.push_back(mk(0,1,8'hBE, 1,0,0,0,1,0,0,1));
    vq.push_back(mk(0,1,8'hAD, 1,0,0,0,1,0,0,1));
    vq.push_back(mk(0,1,8'hDE, 1,0,0,0,1,0,0,1));
    vq.push_back(mk(0,0,8'h00, 0,0,1,32'hDEADBEEF,1,0,0,1));
    vq.push_back(mk(0,0,8'h00, 0,0,0,0,0,1,0,2));
    // Zero count header
    vq.push_back(mk(1,0,8'h00, 0,0,0,0,0,1,0,2));
    vq.push_back(mk(0,0,8'h00, 0,1,0,0,1,0,0,0));
    vq.push_back(mk(0,1,8'h00, 1,0,0,0,1,0,0,0));
    vq.push_back(mk(0,1,8'h00, 1,0,0,0,1,0,0,0));
    vq.push_back(mk(0,0,8'h00, 0,0,0,0,0,1,0,0));
    // Over-limit header 05 00, then restart from ERROR
    vq.push_back(mk(1,0,8'h00, 0,0,0,0,0,1,0,0));
    vq.push_back(mk(0,0,8'h00, 0,1,0,0,1,0,0,0));
    vq.push_back(mk(0,1,8'h05, 1,0,0,0,1,0,0,0));
    vq.push_back(mk(0,1,8'h00, 1,0,0,0,1,0,0,0));
    vq.push_back(mk(0,1,8'hAA, 0,0,0,0,0,0,1,0));
    vq.push_back(mk(0,1,8'hAA, 0,0,0,0,0,0,1,0));
    vq.push_back(mk(1,0,8'h00, 0,0,0,0,0,0,1,0));
    vq.push_back(mk(0,0,8'h00, 0,1,0,0,1,0,0,0));
    // Header 04 00 == limit: accepted, continues into COLLECT
    vq.push_back(mk(0,1,8'h04, 1,0,0,0,1,0,0,0));
    vq.push_back(mk(0,1,8'h00, 1,0,0,0,1,0,0,0));

    // Reset held: all outputs 0
    tick();
    tick();
    chk("in_reset", obs(), 64'd0);
    #2 reset_ni = 1'b1;
    tick();

    foreach (vq[i]) begin
      start_i    = vq[i].start;
      in_valid_i = vq[i].valid;
      in_data_i  = vq[i].data;
      chk($sformatf("vec%0d", i), obs(), expv(vq[i]));
      tick();
    end
    start_i    = 1'b0;
    in_valid_i = 1'b0;

    // Count == limit: four instructions with random valid gaps
    exp_w = '{32'h04030201, 32'hA5A55A5A, 32'h00FF00FF, 32'hCAFEF00D};
    foreach (exp_w[w])
      for (int b = 0; b < 4; b++) tx_q.push_back(exp_w[w][8*b +: 8]);
    send(1'b1, 400);
    chk("limit_done", 64'(done_o), 64'd1);
    chk("limit_count", 64'(loaded_count_o), 64'(LIMIT));
    chk("limit_busy", 64'(busy_o), 64'd0);

    // Mid-session abort after 2 bytes of an instruction
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("abort_clr_pulse", 64'(ctrl_reset_o), 64'd1);
    push(8'h01);
    push(8'h00);
    push(8'hA1);
    push(8'hA2);
    #2 reset_ni = 1'b0;
    #1 chk("abort_outputs", obs() | 64'(load_inst_o), 64'd0);
    tick();
    reset_ni = 1'b1;
    tick();

    // Fresh session must assemble from byte index 0
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    push(8'h01);
    push(8'h00);
    exp_w.push_back(32'h44332211);
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send(1'b0, 100);
    chk("fresh_done", 64'(done_o), 64'd1);
    chk("fresh_count", 64'(loaded_count_o), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so a stuck DUT still reaches the summary line.
  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Host-side program loader driving the control unit's instruction-load port. It accepts a byte stream over a valid/ready handshake, checks a 16-bit instruction-count header against the instruction store size, and assembles little-endian `INST_WIDTH` instructions. Each instruction is delivered as a single-cycle load strobe, after a one-cycle clear pulse to the control unit.

## Interface
- `inst_limit`, 1024: instruction store capacity; headers with a larger count are rejected.
- `BPI` (localparam), `INST_WIDTH/8`: bytes per instruction. `INST_WIDTH` must be a multiple of 8.
- `cnt_width` (localparam), `$clog2(inst_limit+1)`: width of the instruction counters.
- `clk_i`  in  1  clock.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  begin a load session; acted on only in IDLE, DONE or ERROR.
- `in_valid_i`  in  1  host byte valid.
- `in_data_i`  in  8  host byte.
- `in_ready_o`  out  1  loader can accept a byte.
- `ctrl_reset_o`  out  1  clear pulse to the control unit.
- `load_o`  out  1  instruction strobe to the control unit.
- `load_inst_o`  out  `INST_WIDTH`  instruction qualified by `load_o`.
- `busy_o`  out  1  session active (CLEAR, HDR_LO, HDR_HI, COLLECT, EMIT).
- `done_o`  out  1  level; high in DONE.
- `err_o`  out  1  level; high in ERROR.
- `loaded_count_o`  out  `cnt_width`  instructions emitted this session.

## Operation
- FSM states: IDLE, CLEAR, HDR_LO, HDR_HI, COLLECT, EMIT, DONE, ERROR.
- IDLE, DONE, ERROR + `start_i` → CLEAR. Otherwise these states hold.
- CLEAR: `ctrl_reset_o`=1 for exactly one cycle. Clears `loaded_count_o`, the byte index and the assembly register. Next state: HDR_LO.
- HDR_LO / HDR_HI: `in_ready_o`=1. Each accepted byte (`in_valid_i && in_ready_o`) forms `count[7:0]` then `count[15:8]`.
- On the HDR_HI accept:
  - count == 0 → DONE.
  - count > `inst_limit` → ERROR.
  - otherwise `remaining` = count, next state COLLECT.
- COLLECT: `in_ready_o`=1. Byte k of the instruction (k = 0..BPI-1) is written to bits [8k+7:8k]. On the accept of byte BPI-1, next state is EMIT and the byte index returns to 0.
- EMIT: `load_o`=1 and `in_ready_o`=0 for one cycle; `load_inst_o` holds the assembled word.
  - `loaded_count_o` increments and `remaining` decrements.
  - `remaining` reaching 0 → DONE; otherwise → COLLECT.
- ERROR: `in_ready_o`=0. No `load_o` is issued. Bytes already pushed by the host are not drained.
- `start_i` in any busy state is ignored.
- `load_o` and `ctrl_reset_o` are never high in the same cycle.
- `load_o` never asserts in a session before that session's `ctrl_reset_o` pulse.
- Bytes presented while `in_ready_o`=0 are not consumed; the host must hold them.

## Timing
- All outputs are registered. Reset values: all outputs 0; state is IDLE; `load_inst_o`=0.
- Asynchronous assertion of `reset_ni` mid-session aborts immediately to IDLE with all outputs 0. No partial instruction is emitted.
- `start_i` seen at edge N: `ctrl_reset_o` is high in cycle N+1, and `in_ready_o` rises in cycle N+2.
- Steady state: one instruction per BPI+1 cycles with back-to-back valid bytes. The `load_o` strobe follows the final byte's accept edge by one cycle.
- `done_o` rises in the cycle after the last EMIT. It stays high until the next `start_i` or reset.
- Count == `inst_limit` is accepted; `inst_limit`+1 → ERROR.
- `remaining` decrementing to 0 in EMIT goes to DONE. The counter never wraps.
- `loaded_count_o` cannot overflow because count ≤ `inst_limit`.

## Structure
- Package `prog_loader_pkg`:
  - `loader_state_e` enum;
  - `HDR_BYTES` = 2;
  - `BYTE_WIDTH` = 8.
- `INST_WIDTH` comes from the shared defines already used by the control unit.
- One sub-module, `inst_packer`, holds the byte index counter and the little-endian shift/assembly register. It has a clear input and a `word_done` output.
- The FSM and counters live in `prog_loader`.

## Test plan
All scenarios use `INST_WIDTH`=32, so BPI=4.

- Reset/idle: hold `reset_ni`=0, then release → all outputs 0 and `in_ready_o`=0 until `start_i`.
- Two-instruction load: `start_i`, then bytes 02 00 | 78 56 34 12 | EF BE AD DE →
  - one `ctrl_reset_o` pulse;
  - `load_o` twice, with 0x12345678 then 0xDEADBEEF;
  - `loaded_count_o`=2 and `done_o`=1.
- Zero count: header 00 00 → `done_o`=1 in the cycle after the header accept; no `load_o`.
- Over-limit: `inst_limit`=4 with header 05 00 → `err_o`=1, `in_ready_o`=0, no `load_o`. A following `start_i` clears `err_o` and pulses `ctrl_reset_o`.
- Backpressure/gaps: randomly deassert `in_valid_i` within an instruction → same `load_inst_o` values. `load_o` is never issued before the 4th byte is accepted.
- Mid-session abort: assert `reset_ni` low after 2 bytes of an instruction → immediate IDLE with all outputs 0. A fresh session then loads correctly from index 0.
